// File: rtl/vga_frame_scheduler_if.sv
// Frame-state access handshake between game logic (master) and the VGA scheduler (slave).
interface vga_frame_scheduler_if;
  logic upd_req;
  logic upd_gnt;

  modport master (output upd_req, input upd_gnt);
  modport slave  (input upd_req, output upd_gnt);
endinterface

// File: rtl/vga_frame_scheduler.sv
// VGA timing master: sync/blank timing, pixel and lookahead fetch coordinates, and
// vblank-only arbitration of frame-state access for game logic.
module vga_frame_scheduler #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned LOOKAHEAD = 2,
  parameter int unsigned GUARD     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_en,
  vga_frame_scheduler_if.slave upd,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [9:0]           hpos,
  output logic [9:0]           vpos,
  output logic [9:0]           fetch_x,
  output logic [9:0]           fetch_y,
  output logic                 fetch_valid,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [7:0]           frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAct      = 10'(H_ACTIVE);
  localparam logic [9:0] VAct      = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WinEnd    = 10'(V_TOTAL - GUARD);
  localparam logic [9:0] FetchInit = 10'(LOOKAHEAD);

  typedef enum logic [1:0] {StIdle, StGrant, StRevoke} state_e;

  state_e     state_q, state_d;
  logic [9:0] hpos_d, vpos_d, fetch_x_d, fetch_y_d;
  logic [7:0] frame_cnt_d;
  logic       win_now, win_next;

  // Display and fetch counter pairs advance in lockstep; the fetch pair is never derived
  // from the display pair so the lead is set purely by its reset value.
  always_comb begin
    hpos_d      = hpos;
    vpos_d      = vpos;
    fetch_x_d   = fetch_x;
    fetch_y_d   = fetch_y;
    frame_cnt_d = frame_cnt;
    if (pix_en) begin
      if (hpos == HLast) begin
        hpos_d = '0;
        if (vpos == VLast) begin
          vpos_d      = '0;
          frame_cnt_d = frame_cnt + 8'd1;
        end else begin
          vpos_d = vpos + 10'd1;
        end
      end else begin
        hpos_d = hpos + 10'd1;
      end
      if (fetch_x == HLast) begin
        fetch_x_d = '0;
        fetch_y_d = (fetch_y == VLast) ? '0 : fetch_y + 10'd1;
      end else begin
        fetch_x_d = fetch_x + 10'd1;
      end
    end
  end

  assign win_now  = (vpos >= VAct) && (vpos < WinEnd);
  assign win_next = (vpos_d >= VAct) && (vpos_d < WinEnd);

  // A new grant must land inside the window, so the upcoming line is checked too.
  always_comb begin
    state_d = state_q;
    if (pix_en) begin
      unique case (state_q)
        StIdle:   if (upd.upd_req && win_now && win_next) state_d = StGrant;
        StGrant: begin
          if (!win_now)          state_d = StRevoke;
          else if (!upd.upd_req) state_d = StIdle;
        end
        StRevoke: if (!upd.upd_req) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      fetch_x     <= FetchInit;
      fetch_y     <= '0;
      frame_cnt   <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b1;
      fetch_valid <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      state_q     <= StIdle;
      upd.upd_gnt <= 1'b0;
    end else begin
      hpos        <= hpos_d;
      vpos        <= vpos_d;
      fetch_x     <= fetch_x_d;
      fetch_y     <= fetch_y_d;
      frame_cnt   <= frame_cnt_d;
      hsync       <= (hpos_d >= HsStart && hpos_d < HsEnd) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (vpos_d >= VsStart && vpos_d < VsEnd) ? SYNC_POL : ~SYNC_POL;
      de          <= (hpos_d < HAct) && (vpos_d < VAct);
      fetch_valid <= (fetch_x_d < HAct) && (fetch_y_d < VAct);
      line_start  <= (hpos_d == '0);
      frame_start <= (hpos_d == '0) && (vpos_d == '0);
      state_q     <= state_d;
      upd.upd_gnt <= (state_d == StGrant);
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Self-checking bench for vga_frame_scheduler using a reduced raster so whole frames
// and the frame counter wrap fit in a short run.
module tb_vga_frame_scheduler;

  localparam int unsigned HA = 8, HFP = 1, HS = 2, HB = 2;
  localparam int unsigned VA = 6, VFP = 2, VS = 1, VB = 3;
  localparam int unsigned LA = 2, GD = 2;
  localparam bit          POL = 1'b0;
  localparam int unsigned HT = HA + HFP + HS + HB;
  localparam int unsigned VT = VA + VFP + VS + VB;
  localparam int unsigned FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       hsync, vsync, de, fetch_valid, line_start, frame_start;
  logic [9:0] hpos, vpos, fetch_x, fetch_y;
  logic [7:0] frame_cnt;

  vga_frame_scheduler_if bus ();

  vga_frame_scheduler #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL), .LOOKAHEAD (LA), .GUARD (GD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .upd         (bus),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .hpos        (hpos),
    .vpos        (vpos),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .fetch_valid (fetch_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: t counts pixel strobes since reset; every timing output is plain
  // arithmetic on t. Grant state is tracked as two flags.
  int t = 0;
  bit m_gnt = 1'b0;
  bit m_drop = 1'b0;

  logic [54:0] dut_vec;
  assign dut_vec = {hsync, vsync, de, hpos, vpos, fetch_x, fetch_y, fetch_valid,
                    line_start, frame_start, frame_cnt, bus.upd_gnt};

  function automatic int mh(int s); return s % HT; endfunction
  function automatic int mv(int s); return (s / HT) % VT; endfunction
  function automatic bit in_w(int v); return (v >= VA) && (v < VT - GD); endfunction

  function automatic logic [54:0] exp_vec();
    int h  = mh(t);
    int v  = mv(t);
    int fx = (t + LA) % HT;
    int fy = ((t + LA) / HT) % VT;
    logic hs = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
    logic vs = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
    logic e  = (h < HA) && (v < VA);
    logic fv = (fx < HA) && (fy < VA);
    logic ls = (h == 0);
    logic fs = (h == 0) && (v == 0);
    return {hs, vs, e, 10'(h), 10'(v), 10'(fx), 10'(fy), fv, ls, fs,
            8'((t / FT) % 256), m_gnt};
  endfunction

  task automatic model_strobe(input bit req);
    int v  = mv(t);
    int vn = mv(t + 1);
    if (m_gnt) begin
      if (!in_w(v)) begin
        m_gnt  = 1'b0;
        m_drop = 1'b1;
      end else if (!req) begin
        m_gnt = 1'b0;
      end
    end else if (m_drop) begin
      if (!req) m_drop = 1'b0;
    end else if (req && in_w(v) && in_w(vn)) begin
      m_gnt = 1'b1;
    end
    t++;
  endtask

  task automatic model_reset();
    t = 0;
    m_gnt = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic step(input bit en, input bit req);
    pix_en = en;
    bus.upd_req = req;
    @(posedge clk);
    if (en) model_strobe(req);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pix_en = 1'b0;
    bus.upd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec());
    end
    checks++;
    if ({de, line_start, frame_start, fetch_valid, fetch_x} !== {4'b1111, 10'(LA)}) begin
      failures++;
      $display("FAIL reset_literals got=%b_%0d exp=1111_%0d",
               {de, line_start, frame_start, fetch_valid}, fetch_x, LA);
    end
  endtask

  task automatic test_line_scan();
    for (int i = 0; i < 3 * HT; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL line_scan t=%0d got=%h exp=%h", t, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_frame_period();
    int n = 0;
    while (mh(t) != 0 || mv(t) != 0) step(1'b1, 1'b0);
    do begin
      step(1'b1, 1'b0);
      n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL frame_scan t=%0d got=%h exp=%h", t, dut_vec, exp_vec());
      end
    end while (frame_start !== 1'b1 && n < 2 * FT);
    checks++;
    if (n != FT) begin
      failures++;
      $display("FAIL frame_period got=%0d exp=%0d", n, FT);
    end
  endtask

  task automatic test_fetch_boundary();
    while (!(mh(t) == HA - 2 && mv(t) == VA - 1)) step(1'b1, 1'b0);
    checks++;
    if ({fetch_x, fetch_y, fetch_valid} !== {10'(HA), 10'(VA - 1), 1'b0}) begin
      failures++;
      $display("FAIL fetch_edge_active got=(%0d,%0d,%b) exp=(%0d,%0d,0)",
               fetch_x, fetch_y, fetch_valid, HA, VA - 1);
    end
    while (!(mh(t) == HT - 1 && mv(t) == VT - 1)) step(1'b1, 1'b0);
    checks++;
    if ({fetch_x, fetch_y, fetch_valid} !== {10'd1, 10'd0, 1'b1}) begin
      failures++;
      $display("FAIL fetch_wrap got=(%0d,%0d,%b) exp=(1,0,1)", fetch_x, fetch_y, fetch_valid);
    end
  endtask

  task automatic test_grant_window();
    apply_reset();
    while (mv(t) != 2) step(1'b1, 1'b0);
    for (int i = 0; i < FT && !(mh(t) == 2 && mv(t) == VT - GD); i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL grant_scan t=%0d got=%h exp=%h", t, dut_vec, exp_vec());
      end
      if ((mh(t) == 0 && mv(t) == VA) || (mh(t) == 1 && mv(t) == VT - GD)) begin
        checks++;
        if (bus.upd_gnt !== 1'b0) begin
          failures++;
          $display("FAIL grant_edge_low pos=(%0d,%0d) got=%b exp=0", mh(t), mv(t), bus.upd_gnt);
        end
      end
      if ((mh(t) == 1 && mv(t) == VA) || (mh(t) == 0 && mv(t) == VT - GD)) begin
        checks++;
        if (bus.upd_gnt !== 1'b1) begin
          failures++;
          $display("FAIL grant_edge_high pos=(%0d,%0d) got=%b exp=1", mh(t), mv(t), bus.upd_gnt);
        end
      end
    end
  endtask

  task automatic test_held_request();
    while (!(mh(t) == 3 && mv(t) == VA)) begin
      step(1'b1, 1'b1);
      checks++;
      if (bus.upd_gnt !== 1'b0) begin
        failures++;
        $display("FAIL held_req_no_regrant pos=(%0d,%0d) got=%b exp=0",
                 mh(t), mv(t), bus.upd_gnt);
      end
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (bus.upd_gnt !== 1'b1) begin
      failures++;
      $display("FAIL regrant_after_drop got=%b exp=1", bus.upd_gnt);
    end
  endtask

  task automatic test_last_window_strobe();
    apply_reset();
    while (!(mh(t) == HT - 1 && mv(t) == VT - GD - 1)) step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (bus.upd_gnt !== 1'b0) begin
        failures++;
        $display("FAIL late_req_grant step=%0d got=%b exp=0", i, bus.upd_gnt);
      end
    end
  endtask

  task automatic test_pix_en_toggle();
    int h0 = mh(t);
    for (int i = 0; i < 40; i++) begin
      step(i[0] == 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL toggle_scan i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (hpos !== 10'((h0 + 20) % HT)) begin
      failures++;
      $display("FAIL toggle_rate got=%0d exp=%0d", hpos, (h0 + 20) % HT);
    end
  endtask

  task automatic test_random();
    bit req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) req = ~req;
      step($urandom_range(0, 3) != 0, req);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random t=%0d got=%h exp=%h", t, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    while (!(mh(t) == 5 && mv(t) == VA + 2)) step(1'b1, 1'b1);
    checks++;
    if (bus.upd_gnt !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_grant got=%b exp=1", bus.upd_gnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec, exp_vec());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_frame_wrap();
    bit req = 1'b0;
    apply_reset();
    for (int i = 0; i < 256 * FT; i++) begin
      if ($urandom_range(0, 31) == 0) req = ~req;
      step(1'b1, req);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL wrap_scan t=%0d got=%h exp=%h", t, dut_vec, exp_vec());
      end
      if (i == 256 * FT - 2) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          failures++;
          $display("FAIL frame_cnt_max got=%0d exp=255", frame_cnt);
        end
      end
    end
    checks++;
    if ({frame_cnt, frame_start} !== {8'd0, 1'b1}) begin
      failures++;
      $display("FAIL frame_cnt_wrap got=%0d/%b exp=0/1", frame_cnt, frame_start);
    end
  endtask

  initial begin
    bus.upd_req = 1'b0;
    test_reset();
    test_line_scan();
    test_frame_period();
    test_fetch_boundary();
    test_grant_window();
    test_held_request();
    test_last_window_strobe();
    test_pix_en_toggle();
    test_random();
    test_async_reset();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
